// File: rtl/interrupt_controller_pkg.sv
// Shared request codes and FSM state encoding for the screen-processor
// interrupt controller.
package interrupt_controller_pkg;

    localparam logic [1:0] IRQ_TIMER = 2'd0;
    localparam logic [1:0] IRQ_KBD   = 2'd1;
    localparam logic [1:0] IRQ_NONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAISE   = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/kbd_fifo.sv
// Circular-buffer FIFO for keyboard scan codes. Pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
module kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees a slot on the same edge, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers define validity and head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/interrupt_controller.sv
// Responder side of the INT_IRQ/INT_IACK/INT_IEND handshake: latches timer and
// keyboard events and presents one request at a time, timer first.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int KBD_DEPTH    = 4,
    parameter int IEND_TIMEOUT = 1024
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK,
    input  logic       KBD_VALID,
    input  logic [7:0] KBD_CODE,
    output logic [1:0] INT_IRQ,
    input  logic       INT_IACK,
    input  logic       INT_IEND,
    output logic [7:0] KBD_KEY,
    output logic       TICK_OVERRUN,
    output logic       KBD_OVERFLOW,
    output logic       PROTO_ERR,
    input  logic       CLR_FLAGS
);

    localparam int              CW       = $clog2(IEND_TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(IEND_TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(IEND_TIMEOUT);

    state_e        state_q, state_d;
    logic [1:0]    irq_q, irq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_pend_q, tick_pend_d;
    logic          overrun_q, overrun_d;
    logic          overflow_q, overflow_d;
    logic          proto_q, proto_d;
    logic          fifo_pop, fifo_full, fifo_empty, tick_ack, proto_set;

    kbd_fifo #(.DEPTH(KBD_DEPTH), .WIDTH(8)) u_kbd_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (KBD_VALID),
        .pop   (fifo_pop),
        .din   (KBD_CODE),
        .head  (KBD_KEY),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        irq_d     = irq_q;
        cnt_d     = cnt_q;
        fifo_pop  = 1'b0;
        tick_ack  = 1'b0;
        proto_set = (INT_IACK && state_q != ST_RAISE) ||
                    (INT_IEND && state_q != ST_SERVICE);

        case (state_q)
            ST_IDLE: begin
                if (tick_pend_q) begin
                    state_d = ST_RAISE;
                    irq_d   = IRQ_TIMER;
                end else if (!fifo_empty) begin
                    state_d = ST_RAISE;
                    irq_d   = IRQ_KBD;
                end
            end
            ST_RAISE: begin
                if (INT_IACK) begin
                    state_d  = ST_SERVICE;
                    irq_d    = IRQ_NONE;
                    cnt_d    = '0;
                    fifo_pop = (irq_q == IRQ_KBD);
                    tick_ack = (irq_q == IRQ_TIMER);
                end
            end
            ST_SERVICE: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                if (INT_IEND) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    // Processor went away mid-service: abort so new events are not starved.
                    state_d   = ST_IDLE;
                    proto_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tick_pend_d = TICK || (tick_pend_q && !tick_ack);
        overrun_d   = (TICK && tick_pend_q) || (overrun_q && !CLR_FLAGS);
        overflow_d  = (KBD_VALID && fifo_full && !fifo_pop) || (overflow_q && !CLR_FLAGS);
        proto_d     = proto_set || (proto_q && !CLR_FLAGS);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            irq_q       <= IRQ_NONE;
            cnt_q       <= '0;
            tick_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            overflow_q  <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            cnt_q       <= cnt_d;
            tick_pend_q <= tick_pend_d;
            overrun_q   <= overrun_d;
            overflow_q  <= overflow_d;
            proto_q     <= proto_d;
        end
    end

    assign INT_IRQ      = irq_q;
    assign TICK_OVERRUN = overrun_q;
    assign KBD_OVERFLOW = overflow_q;
    assign PROTO_ERR    = proto_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed handshake scenarios plus random traffic, all
// compared against an event-level reference model.
module tb_interrupt_controller;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       CLK, RESET, TICK, KBD_VALID, INT_IACK, INT_IEND, CLR_FLAGS;
    logic [7:0] KBD_CODE, KBD_KEY;
    logic [1:0] INT_IRQ;
    logic       TICK_OVERRUN, KBD_OVERFLOW, PROTO_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    interrupt_controller #(.KBD_DEPTH(DEPTH), .IEND_TIMEOUT(TMO)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .TICK         (TICK),
        .KBD_VALID    (KBD_VALID),
        .KBD_CODE     (KBD_CODE),
        .INT_IRQ      (INT_IRQ),
        .INT_IACK     (INT_IACK),
        .INT_IEND     (INT_IEND),
        .KBD_KEY      (KBD_KEY),
        .TICK_OVERRUN (TICK_OVERRUN),
        .KBD_OVERFLOW (KBD_OVERFLOW),
        .PROTO_ERR    (PROTO_ERR),
        .CLR_FLAGS    (CLR_FLAGS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: pending tick, code queue, the request being offered
    // (-1 = none), whether a service is open and how long it has run.
    bit         m_pend, m_serv, m_ovr, m_ofl, m_perr;
    logic [7:0] m_q[$];
    int         m_raised, m_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_serv = 0; m_ovr = 0; m_ofl = 0; m_perr = 0;
        m_q.delete();
        m_raised = -1; m_cyc = 0;
    endtask

    task automatic model_edge(input bit tick, input bit kv, input logic [7:0] code,
                              input bit iack, input bit iend, input bit clr);
        bit s_ovr, s_ofl, s_perr, old_pend, ack_t, ack_k;
        int old_n;
        old_pend = m_pend;
        old_n    = m_q.size();
        ack_t    = iack && m_raised == 0;
        ack_k    = iack && m_raised == 1;
        s_ovr    = tick && m_pend;
        s_ofl    = 0;
        s_perr   = (iack && m_raised < 0) || (iend && !m_serv);
        if (kv) begin
            if (old_n < DEPTH || ack_k) m_q.push_back(code);
            else s_ofl = 1;
        end
        if (ack_k) void'(m_q.pop_front());
        m_pend = tick || (m_pend && !ack_t);
        if (m_raised >= 0) begin
            if (iack) begin
                m_raised = -1; m_serv = 1; m_cyc = 0;
            end
        end else if (m_serv) begin
            if (iend) m_serv = 0;
            else begin
                m_cyc++;
                if (m_cyc == TMO) begin
                    m_serv = 0; s_perr = 1;
                end
            end
        end else if (old_pend) m_raised = 0;
        else if (old_n > 0) m_raised = 1;
        m_ovr  = s_ovr  || (m_ovr  && !clr);
        m_ofl  = s_ofl  || (m_ofl  && !clr);
        m_perr = s_perr || (m_perr && !clr);
    endtask

    task automatic compare_model();
        check("irq",      32'(INT_IRQ), m_raised < 0 ? 32'd3 : 32'(m_raised));
        check("kbd_key",  32'(KBD_KEY), m_q.size() > 0 ? 32'(m_q[0]) : 32'd0);
        check("overrun",  32'(TICK_OVERRUN), 32'(m_ovr));
        check("overflow", 32'(KBD_OVERFLOW), 32'(m_ofl));
        check("proto",    32'(PROTO_ERR), 32'(m_perr));
    endtask

    // Drive one cycle of inputs (called at a negedge) and check after the edge.
    task automatic step(input bit tick, input bit kv, input logic [7:0] code,
                        input bit iack, input bit iend, input bit clr);
        TICK = tick; KBD_VALID = kv; KBD_CODE = code;
        INT_IACK = iack; INT_IEND = iend; CLR_FLAGS = clr;
        model_edge(tick, kv, code, iack, iend, clr);
        @(posedge CLK);
        @(negedge CLK);
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic wait_irq(input string tag, input logic [1:0] exp);
        int n = 0;
        while (INT_IRQ == 2'd3 && n < 10) begin
            step(0, 0, 8'h00, 0, 0, 0);
            n++;
        end
        check(tag, 32'(INT_IRQ), 32'(exp));
    endtask

    task automatic serve(input string tag, input logic [1:0] exp);
        wait_irq(tag, exp);
        step(0, 0, 8'h00, 1, 0, 0);
        step(0, 0, 8'h00, 0, 1, 0);
    endtask

    initial begin
        RESET = 1; TICK = 0; KBD_VALID = 0; KBD_CODE = 0;
        INT_IACK = 0; INT_IEND = 0; CLR_FLAGS = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        RESET = 0;
        check("rst_irq", 32'(INT_IRQ), 32'd3);
        check("rst_key", 32'(KBD_KEY), 32'd0);
        check("rst_flags", 32'({TICK_OVERRUN, KBD_OVERFLOW, PROTO_ERR}), 32'd0);

        // Timer request: raised two edges after the tick, dropped on IACK.
        step(1, 0, 8'h00, 0, 0, 0);
        check("t1_irq_edge1", 32'(INT_IRQ), 32'd3);
        idle(1);
        check("t1_irq_edge2", 32'(INT_IRQ), 32'd0);
        idle(2);
        step(0, 0, 8'h00, 1, 0, 0);
        check("t1_after_iack", 32'(INT_IRQ), 32'd3);
        idle(4);
        step(0, 0, 8'h00, 0, 1, 0);
        idle(2);

        // Two key codes served in order, then the head reads zero.
        step(0, 1, 8'h20, 0, 0, 0);
        step(0, 1, 8'h1C, 0, 0, 0);
        wait_irq("t2_irq1", 2'd1);
        check("t2_key1", 32'(KBD_KEY), 32'h20);
        step(0, 0, 8'h00, 1, 0, 0);
        idle(2);
        step(0, 0, 8'h00, 0, 1, 0);
        wait_irq("t2_irq2", 2'd1);
        check("t2_key2", 32'(KBD_KEY), 32'h1C);
        step(0, 0, 8'h00, 1, 0, 0);
        step(0, 0, 8'h00, 0, 1, 0);
        idle(3);
        check("t2_key_empty", 32'(KBD_KEY), 32'h00);

        // Simultaneous tick and key: timer wins.
        step(1, 1, 8'h29, 0, 0, 0);
        serve("t3_timer_first", 2'd0);
        wait_irq("t3_kbd_second", 2'd1);
        check("t3_key", 32'(KBD_KEY), 32'h29);
        step(0, 0, 8'h00, 1, 0, 0);
        step(0, 0, 8'h00, 0, 1, 0);
        idle(2);

        // Overflow, overrun and flag clear.
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0, 0, 0);
        check("t4_overflow", 32'(KBD_OVERFLOW), 32'd1);
        step(1, 0, 8'h00, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0);
        check("t4_overrun", 32'(TICK_OVERRUN), 32'd1);
        step(0, 0, 8'h00, 0, 0, 1);
        check("t4_clr", 32'({TICK_OVERRUN, KBD_OVERFLOW}), 32'd0);
        serve("t4_s1", 2'd1);
        serve("t4_s2", 2'd0);
        serve("t4_s3", 2'd1);
        serve("t4_s4", 2'd1);
        serve("t4_s5", 2'd1);
        idle(2);
        check("t4_drained", 32'(KBD_KEY), 32'h00);

        // Protocol errors and timeout abort with re-raise of queued work.
        step(0, 0, 8'h00, 1, 0, 0);
        check("t5_iack_idle", 32'(PROTO_ERR), 32'd1);
        step(1, 0, 8'h00, 0, 0, 1);
        wait_irq("t5_raise", 2'd0);
        step(0, 0, 8'h00, 0, 1, 0);
        check("t5_iend_raise", 32'(PROTO_ERR), 32'd1);
        check("t5_irq_kept", 32'(INT_IRQ), 32'd0);
        step(0, 0, 8'h00, 0, 0, 1);
        step(0, 0, 8'h00, 1, 0, 0);
        step(0, 1, 8'h33, 0, 0, 0);
        idle(TMO - 2);
        check("t5_before_tmo", 32'(PROTO_ERR), 32'd0);
        idle(1);
        check("t5_timeout", 32'(PROTO_ERR), 32'd1);
        wait_irq("t5_reraise", 2'd1);
        check("t5_key", 32'(KBD_KEY), 32'h33);
        step(0, 0, 8'h00, 1, 0, 1);
        step(0, 0, 8'h00, 0, 1, 0);

        // Async reset mid-service with codes queued.
        step(1, 0, 8'h00, 0, 0, 0);
        wait_irq("t6_raise", 2'd0);
        step(0, 0, 8'h00, 1, 0, 0);
        step(0, 1, 8'h11, 0, 0, 0);
        step(0, 1, 8'h22, 0, 0, 0);
        step(0, 1, 8'h33, 1, 0, 0);
        #2 RESET = 1;
        #1;
        check("t6_irq", 32'(INT_IRQ), 32'd3);
        check("t6_key", 32'(KBD_KEY), 32'd0);
        check("t6_flags", 32'({TICK_OVERRUN, KBD_OVERFLOW, PROTO_ERR}), 32'd0);
        TICK = 0; KBD_VALID = 0; INT_IACK = 0; INT_IEND = 0; CLR_FLAGS = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        RESET = 0;
        idle(5);
        check("t6_quiet", 32'(INT_IRQ), 32'd3);

        // Random traffic with a processor that sometimes misbehaves or stalls.
        for (int c = 0; c < 3000; c++) begin
            bit tick, kv, iack, iend, clr, stall;
            stall = ((c / 200) % 3) == 2;
            tick  = ($urandom % 16) == 0;
            kv    = ($urandom % 6) == 0;
            iack  = (m_raised >= 0) ? ($urandom % 3) == 0 : ($urandom % 50) == 0;
            iend  = m_serv ? (!stall && ($urandom % 4) == 0) : ($urandom % 60) == 0;
            clr   = ($urandom % 40) == 0;
            step(tick, kv, 8'($urandom), iack, iend, clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
